// File: rtl/decimate_pack_pkg.sv
// Shared constants and state encoding for the pixel decimate/pack block and
// its parent regeneration engine.
package decimate_pack_pkg;

   localparam int unsigned DP_BITS_PER_BYTE = 7;
   localparam int unsigned STRETCH_W        = 8;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      STRETCH = 1'b1
   } dp_state_t;

   // A stretch factor of zero behaves as one pixel per sample.
   function automatic logic [STRETCH_W-1:0] eff_stretch(input logic [STRETCH_W-1:0] sf);
      return (sf == '0) ? STRETCH_W'(1) : sf;
   endfunction

endpackage : decimate_pack_pkg

// File: rtl/decimate_pack.sv
// Stretches single-bit logic samples into runs of pixels and packs the pixels
// LSB-first into BITS_PER_BYTE-wide output bytes, with an explicit flush.
module decimate_pack
   import decimate_pack_pkg::*;
#(
   parameter int unsigned BITS_PER_BYTE = DP_BITS_PER_BYTE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     sample_in,
   input  logic                     sample_valid,
   input  logic                     flush,
   input  logic [STRETCH_W-1:0]     stretch_factor,
   output logic [BITS_PER_BYTE-1:0] byte_out,
   output logic                     byte_valid,
   output logic                     ready
);

   localparam int unsigned CNT_W = $clog2(BITS_PER_BYTE + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

   dp_state_t                state_q, state_d;
   logic                     bit_q;
   logic [STRETCH_W-1:0]     rep_cnt_q;
   logic [BITS_PER_BYTE-1:0] acc_q;
   logic [CNT_W-1:0]         bit_cnt_q;
   logic                     flush_pending_q;

   logic                     accept_c;
   logic                     flush_srv_c;
   logic [BITS_PER_BYTE-1:0] acc_set_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: leave STRETCH on the cycle the repeat counter hits zero
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_valid)              state_d = STRETCH;
         STRETCH: if (rep_cnt_q <= STRETCH_W'(1)) state_d = IDLE;
         default:                                state_d = IDLE;
      endcase
   end

   // Output / control decode; a sample always wins over a flush in IDLE
   always_comb begin
      ready       = 1'b0;
      accept_c    = 1'b0;
      flush_srv_c = 1'b0;
      if (state_q == IDLE) begin
         ready       = 1'b1;
         accept_c    = sample_valid;
         flush_srv_c = !sample_valid && (flush_pending_q || flush);
      end
   end

   assign acc_set_c = acc_q | (BITS_PER_BYTE'(bit_q) << bit_cnt_q);

   // Sample latch, repeat counter, accumulator and byte output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_q           <= 1'b0;
         rep_cnt_q       <= '0;
         acc_q           <= '0;
         bit_cnt_q       <= '0;
         flush_pending_q <= 1'b0;
         byte_out        <= '0;
         byte_valid      <= 1'b0;
      end else if (clr) begin
         bit_q           <= 1'b0;
         rep_cnt_q       <= '0;
         acc_q           <= '0;
         bit_cnt_q       <= '0;
         flush_pending_q <= 1'b0;
         byte_out        <= '0;
         byte_valid      <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (flush) begin
            flush_pending_q <= 1'b1;
         end

         if (accept_c) begin
            bit_q     <= sample_in;
            rep_cnt_q <= eff_stretch(stretch_factor);
         end else if (flush_srv_c) begin
            flush_pending_q <= 1'b0;
            acc_q           <= '0;
            bit_cnt_q       <= '0;
            if (bit_cnt_q != '0) begin
               byte_out   <= acc_q;
               byte_valid <= 1'b1;
            end
         end

         if (state_q == STRETCH) begin
            rep_cnt_q <= rep_cnt_q - STRETCH_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
               byte_out   <= acc_set_c;
               byte_valid <= 1'b1;
               acc_q      <= '0;
               bit_cnt_q  <= '0;
            end else begin
               acc_q     <= acc_set_c;
               bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule : decimate_pack

// File: tb/tb_decimate_pack.sv
// Directed bench for decimate_pack: table of stretch/pattern vectors plus
// hand-written sequences for reset, flush collision and busy-sample cases.
module tb_decimate_pack;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       sample_in;
   logic       sample_valid;
   logic       flush;
   logic [7:0] stretch_factor;
   logic [6:0] byte_out;
   logic       byte_valid;
   logic       ready;

   int n_cmp = 0;
   int n_err = 0;
   logic [6:0] got_q[$];

   typedef struct {
      logic [7:0]  stretch;
      int          n_samples;
      logic [31:0] pattern;    // sample i = pattern[i % 32]
      logic        do_flush;
      int          exp_bytes;
      logic [6:0]  exp_first;
      logic [6:0]  exp_last;
      int          exp_low;    // ready-low cycles after the first sample
   } vec_t;

   vec_t vecs[6];

   decimate_pack #(.BITS_PER_BYTE(7)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clr            (clr),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .flush          (flush),
      .stretch_factor (stretch_factor),
      .byte_out       (byte_out),
      .byte_valid     (byte_valid),
      .ready          (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && byte_valid) got_q.push_back(byte_out);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      got_q.delete();
   endtask

   task automatic send_sample(input logic b, output int low);
      int guard = 0;
      while (!ready && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) check("wait_ready", 0, 1);
      sample_in    = b;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      low = 0;
      while (!ready && low < 400) begin
         low++;
         @(negedge clk);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      int low;
      int first_low;

      vecs[0] = '{8'd7, 1,   32'h0000_0001, 1'b0, 1,  7'h7F, 7'h7F, 7};
      vecs[1] = '{8'd1, 7,   32'h0000_004D, 1'b0, 1,  7'h4D, 7'h4D, 1};
      vecs[2] = '{8'd3, 3,   32'h0000_0005, 1'b1, 2,  7'h47, 7'h03, 3};
      vecs[3] = '{8'd2, 133, 32'hFFFF_FFFF, 1'b1, 38, 7'h7F, 7'h7F, 2};
      vecs[4] = '{8'd0, 1,   32'h0000_0001, 1'b1, 1,  7'h01, 7'h01, 1};
      vecs[5] = '{8'd5, 2,   32'h0000_0001, 1'b1, 2,  7'h1F, 7'h00, 5};

      rst_n          = 1'b0;
      clr            = 1'b0;
      sample_in      = 1'b0;
      sample_valid   = 1'b0;
      flush          = 1'b0;
      stretch_factor = 8'd1;
      repeat (3) @(negedge clk);
      check("rst_ready",      int'(ready),      1);
      check("rst_byte_valid", int'(byte_valid), 0);
      check("rst_byte_out",   int'(byte_out),   0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[v]) begin
         do_clr();
         stretch_factor = vecs[v].stretch;
         first_low = 0;
         for (int i = 0; i < vecs[v].n_samples; i++) begin
            send_sample(vecs[v].pattern[i % 32], low);
            if (i == 0) first_low = low;
         end
         if (vecs[v].do_flush) pulse_flush();
         repeat (10) @(negedge clk);
         check($sformatf("v%0d_ready_low", v), first_low, vecs[v].exp_low);
         check($sformatf("v%0d_nbytes", v), got_q.size(), vecs[v].exp_bytes);
         if (got_q.size() > 0) begin
            check($sformatf("v%0d_first", v), int'(got_q[0]), int'(vecs[v].exp_first));
            check($sformatf("v%0d_last", v), int'(got_q[got_q.size()-1]), int'(vecs[v].exp_last));
            check($sformatf("v%0d_hold", v), int'(byte_out), int'(vecs[v].exp_last));
         end
      end

      // Asynchronous reset three bits into a stretch, then flush: nothing emitted
      do_clr();
      stretch_factor = 8'd7;
      sample_in      = 1'b1;
      sample_valid   = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ready",      int'(ready),      1);
      check("async_rst_byte_valid", int'(byte_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse_flush();
      repeat (10) @(negedge clk);
      check("async_rst_nbytes", got_q.size(), 0);

      // Sample and flush together in IDLE: sample first, then the flush
      do_clr();
      stretch_factor = 8'd2;
      for (int i = 0; i < 3; i++) send_sample(1'b1, low);
      sample_in    = 1'b0;
      sample_valid = 1'b1;
      flush        = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      flush        = 1'b0;
      repeat (10) @(negedge clk);
      check("collide_nbytes", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("collide_byte0", int'(got_q[0]), 'h3F);
         check("collide_byte1", int'(got_q[1]), 'h00);
      end

      // Sample while busy is ignored; stretch change mid-stretch has no effect
      do_clr();
      stretch_factor = 8'd3;
      sample_in      = 1'b1;
      sample_valid   = 1'b1;
      @(negedge clk);
      sample_in      = 1'b0;
      stretch_factor = 8'd1;
      @(negedge clk);
      sample_valid = 1'b0;
      low = 1;
      while (!ready && low < 400) begin
         low++;
         @(negedge clk);
      end
      check("busy_ready_low", low, 3);
      pulse_flush();
      repeat (10) @(negedge clk);
      check("busy_nbytes", got_q.size(), 1);
      if (got_q.size() == 1) check("busy_byte", int'(got_q[0]), 'h07);
      check("busy_idle_valid", int'(byte_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_decimate_pack
